// File: rtl/sample_streamer.sv
// rtl/sample_streamer.sv - transmit-side sample sequencer with valid/ready handshake and optional idle gap
module sample_streamer #(
  parameter int CNT_BITS   = 10,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                clear,
  input  logic [CNT_BITS-1:0] num_samples,
  input  logic                sample_ready,
  output logic                sample_valid,
  output logic [CNT_BITS-1:0] sample_idx,
  output logic                busy,
  output logic                done
);

  localparam int GAP_BITS = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_BITS-1:0] remaining;
  logic [GAP_BITS-1:0] gap_cnt;
  logic                xfer;

  assign xfer = (state == SEND) && sample_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = (num_samples != '0) ? SEND : DONE;
          end
        end
        SEND: begin
          if (xfer) begin
            if (remaining == CNT_BITS'(1)) begin
              state_nxt = DONE;
            end else if (GAP_CYCLES == 0) begin
              state_nxt = SEND;
            end else begin
              state_nxt = GAP;
            end
          end
        end
        GAP: begin
          // Leaving on count 1 yields exactly GAP_CYCLES invalid cycles.
          if (gap_cnt <= GAP_BITS'(1)) begin
            state_nxt = SEND;
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      remaining  <= '0;
      sample_idx <= '0;
      gap_cnt    <= '0;
    end else if (clear) begin
      remaining  <= '0;
      sample_idx <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining  <= num_samples;
            sample_idx <= '0;
          end
        end
        SEND: begin
          if (xfer) begin
            remaining  <= remaining - 1'b1;
            sample_idx <= sample_idx + 1'b1;
            gap_cnt    <= GAP_BITS'(GAP_CYCLES);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    sample_valid = (state == SEND);
    busy         = (state != IDLE);
    done         = (state == DONE);
  end

endmodule
